uart_tx_param: RTL and testbench

Parametrised UART transmitter; next generation of the team's fixed 8-bit, 16x-oversampled transmitter. Serialises one word per frame on `txd` with configurable data width, oversample ratio, parity mode and stop-bit count, behind a valid/ready handshake. Sits between a byte or word source (FIFO or register interface) and the serial pin; `bclk` is the oversampled baud clock from the baud generator.

---
 rtl/uart_tx_param.sv | 151 +++++++++++++++
 tb/tb_uart_tx_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// 1 or 2 stop bits, each bit held for OVERSAMPLE bclk cycles; valid/ready input handshake.
module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 bclk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_din,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(2 * DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick_end;

  assign tick_end = (tick_q == TW'(OVERSAMPLE - 1));

  // State and output registers; reset forces the line idle high at once.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; txd_d is the level the line takes for the coming cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_end ? '0 : tick_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        txd_d  = 1'b1;
        if (tx_valid && ready_q) begin
          state_d = S_START;
          shift_d = tx_din;
          par_d   = (PARITY == 1) ? ~(^tx_din) : (^tx_din);
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (tick_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        // Registered pulse lands on the final cycle of the last stop bit.
        if (bit_q == BW'(STOP_BITS - 1) && tick_q == TW'(OVERSAMPLE - 2)) begin
          done_d = 1'b1;
        end
        if (tick_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign ready_d  = (state_d == S_IDLE);
  assign busy_d   = (state_d != S_IDLE);

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1 x16, 7E2 x16, 8O1 x16 and 9N1 x4.
module tb_uart_tx_param;

  logic       bclk = 1'b0;
  logic       reset;
  logic [8:0] din [4];
  logic [3:0] valid;
  logic [3:0] ready_w, busy_w, txd_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 bclk = ~bclk;

  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .bclk(bclk), .reset(reset), .tx_din(din[0][7:0]), .tx_valid(valid[0]),
    .tx_ready(ready_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) dut1 (
    .bclk(bclk), .reset(reset), .tx_din(din[1][6:0]), .tx_valid(valid[1]),
    .tx_ready(ready_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut2 (
    .bclk(bclk), .reset(reset), .tx_din(din[2][7:0]), .tx_valid(valid[2]),
    .tx_ready(ready_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_param #(.DATA_BITS(9), .OVERSAMPLE(4), .PARITY(0), .STOP_BITS(1)) dut3 (
    .bclk(bclk), .reset(reset), .tx_din(din[3]), .tx_valid(valid[3]),
    .tx_ready(ready_w[3]), .txd(txd_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  // One frame: DUT index, word, expected line levels per bit slot (LSB = start bit).
  typedef struct {
    string      name;
    int         k;
    logic [8:0] word;
    logic [15:0] bits;
    int         nbits;
    int         os;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (ready_w[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("dut%0d ready wait", k), 32'(ready_w[k]), 32'd1);
  endtask

  // Samples the line at the first and last cycle of each bit slot, starting at accept+1ns.
  task automatic capture(input int k, input int os, input int nbits,
                         output logic [15:0] v0, output logic [15:0] v1,
                         output int done_cnt, output int done_at, output int busy_low);
    v0 = '0; v1 = '0; done_cnt = 0; done_at = -1; busy_low = 0;
    for (int i = 0; i < nbits * os; i++) begin
      if (i % os == 0)      v0[i / os] = txd_w[k];
      if (i % os == os - 1) v1[i / os] = txd_w[k];
      if (done_w[k] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (busy_w[k] !== 1'b1) busy_low++;
      tick();
    end
  endtask

  task automatic check_frame(input string name, input int k, input logic [15:0] bits,
                             input int nbits, input int os);
    logic [15:0] v0, v1;
    int dc, da, bl;
    capture(k, os, nbits, v0, v1, dc, da, bl);
    check({name, " txd bit start"}, 32'(v0), 32'(bits));
    check({name, " txd bit end"},   32'(v1), 32'(bits));
    check({name, " done count"},    32'(dc), 32'd1);
    check({name, " done cycle"},    32'(da), 32'(nbits * os - 1));
    check({name, " busy low cycles"}, 32'(bl), 32'd0);
    check({name, " ready after"},   32'(ready_w[k]), 32'd1);
    check({name, " busy after"},    32'(busy_w[k]), 32'd0);
    check({name, " txd idle after"}, 32'(txd_w[k]), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    wait_ready(v.k);
    din[v.k]   = v.word;
    valid[v.k] = 1'b1;
    tick();
    valid[v.k] = 1'b0;
    din[v.k]   = ~v.word;
    check_frame(v.name, v.k, v.bits, v.nbits, v.os);
  endtask

  initial begin
    tbl[0] = '{"8N1 A5",  0, 9'h0A5, 16'h034A, 10, 16};
    tbl[1] = '{"8N1 00",  0, 9'h000, 16'h0200, 10, 16};
    tbl[2] = '{"8N1 FF",  0, 9'h0FF, 16'h03FE, 10, 16};
    tbl[3] = '{"7E2 55",  1, 9'h055, 16'h06AA, 11, 16};
    tbl[4] = '{"7E2 2A",  1, 9'h02A, 16'h0754, 11, 16};
    tbl[5] = '{"8O1 00",  2, 9'h000, 16'h0600, 11, 16};
    tbl[6] = '{"8O1 FF",  2, 9'h0FF, 16'h07FE, 11, 16};
    tbl[7] = '{"8O1 01",  2, 9'h001, 16'h0402, 11, 16};
    tbl[8] = '{"9N1x4 1FF", 3, 9'h1FF, 16'h07FE, 11, 4};

    reset = 1'b1;
    valid = 4'b1111;
    for (int k = 0; k < 4; k++) din[k] = 9'h0A5;
    #2;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dut%0d reset txd", k),   32'(txd_w[k]),   32'd1);
      check($sformatf("dut%0d reset ready", k), 32'(ready_w[k]), 32'd0);
      check($sformatf("dut%0d reset busy", k),  32'(busy_w[k]),  32'd0);
      check($sformatf("dut%0d reset done", k),  32'(done_w[k]),  32'd0);
    end
    tick(); tick();
    valid = 4'b0000;
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dut%0d ready after reset", k), 32'(ready_w[k]), 32'd1);
      check($sformatf("dut%0d busy after reset", k),  32'(busy_w[k]),  32'd0);
    end

    for (int i = 0; i < 9; i++) run_frame(tbl[i]);

    // Back-to-back with tx_valid held: one idle cycle between frames, din change ignored.
    wait_ready(0);
    din[0] = 9'h012;
    valid[0] = 1'b1;
    tick();
    check("b2b accept1 txd", 32'(txd_w[0]), 32'd0);
    din[0] = 9'h034;
    begin
      logic [15:0] v0, v1;
      int dc, da, bl;
      capture(0, 16, 10, v0, v1, dc, da, bl);
      check("b2b frame1 bits", 32'(v0), 32'h224);
      check("b2b frame1 bits end", 32'(v1), 32'h224);
      check("b2b frame1 done cycle", 32'(da), 32'd159);
      check("b2b gap busy", 32'(busy_w[0]), 32'd0);
      check("b2b gap txd", 32'(txd_w[0]), 32'd1);
      tick();
      check("b2b accept2 busy", 32'(busy_w[0]), 32'd1);
      check("b2b accept2 txd", 32'(txd_w[0]), 32'd0);
      valid[0] = 1'b0;
      capture(0, 16, 10, v0, v1, dc, da, bl);
      check("b2b frame2 bits", 32'(v0), 32'h268);
      check("b2b frame2 done count", 32'(dc), 32'd1);
    end

    // Reset in data bit 3 aborts the frame; a fresh frame then goes out intact.
    wait_ready(0);
    din[0] = 9'h0A5;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    begin
      int dc;
      dc = 0;
      for (int i = 0; i < 70; i++) begin
        if (done_w[0] === 1'b1) dc++;
        tick();
      end
      check("abort pre txd bit3", 32'(txd_w[0]), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("abort txd", 32'(txd_w[0]), 32'd1);
      check("abort busy", 32'(busy_w[0]), 32'd0);
      check("abort ready", 32'(ready_w[0]), 32'd0);
      din[0] = 9'h03C;
      valid[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (done_w[0] === 1'b1) dc++;
        tick();
      end
      check("abort no done", 32'(dc), 32'd0);
      check("abort held txd", 32'(txd_w[0]), 32'd1);
      reset = 1'b0;
      tick();
      check("post-abort ready", 32'(ready_w[0]), 32'd1);
      check("post-abort busy", 32'(busy_w[0]), 32'd0);
      check("post-abort txd", 32'(txd_w[0]), 32'd1);
      tick();
      valid[0] = 1'b0;
      check("post-abort accept busy", 32'(busy_w[0]), 32'd1);
      check_frame("post-abort 3C", 0, 16'h0278, 10, 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "timeout");
  end

endmodule
